// File: rtl/micro86_mem_pkg.sv
// Shared definitions for the micro86 on-chip memory bus: RAM geometry, arbiter
// state encoding and requester port ids.
package micro86_mem_pkg;

  localparam int unsigned RAM_ADDR_WIDTH = 12;
  localparam int unsigned RAM_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    ACK     = 2'd3
  } arb_state_e;

  localparam logic PORT_CPU    = 1'b0;
  localparam logic PORT_LOADER = 1'b1;

endpackage

// File: rtl/ram_arbiter.sv
// Two-port req/ack arbiter in front of the single-port block RAM. One access per
// four cycles: sample, issue, capture registered read data, acknowledge.
module ram_arbiter
  import micro86_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = RAM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = RAM_DATA_WIDTH,
  parameter int unsigned FIXED_PRIORITY = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  ack0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_write_enable,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  arb_state_e            state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  last_grant_q, last_grant_d;
  logic                  is_write_q, is_write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  we_q, we_d;
  logic                  ack0_q, ack0_d, ack1_q, ack1_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                  pick_loader;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    is_write_d   = is_write_q;
    addr_d       = addr_q;
    din_d        = din_q;
    we_d         = we_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    pick_loader  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // Ties go to port 0 under fixed priority, else to whoever did not win last.
          if (req0 && req1) begin
            pick_loader = (FIXED_PRIORITY == 0) && (last_grant_q == PORT_CPU);
          end else begin
            pick_loader = req1;
          end
          grant_d    = pick_loader ? PORT_LOADER : PORT_CPU;
          addr_d     = pick_loader ? addr1 : addr0;
          din_d      = pick_loader ? wdata1 : wdata0;
          we_d       = pick_loader ? we1 : we0;
          is_write_d = pick_loader ? we1 : we0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        we_d    = 1'b0;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        if (!is_write_q) begin
          if (grant_q == PORT_LOADER) begin
            rdata1_d = ram_data_out;
          end else begin
            rdata0_d = ram_data_out;
          end
        end
        ack0_d       = (grant_q == PORT_CPU);
        ack1_d       = (grant_q == PORT_LOADER);
        last_grant_d = grant_q;
        state_d      = ACK;
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      grant_q      <= PORT_CPU;
      last_grant_q <= PORT_LOADER;
      is_write_q   <= 1'b0;
      addr_q       <= '0;
      din_q        <= '0;
      we_q         <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      is_write_q   <= is_write_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      we_q         <= we_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign ack0             = ack0_q;
  assign ack1             = ack1_q;
  assign rdata0           = rdata0_q;
  assign rdata1           = rdata1_q;
  assign ram_address      = addr_q;
  assign ram_data_in      = din_q;
  assign ram_write_enable = we_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a cycle-schedule model of the arbiter plus directed
// requester sequences, and a fixed-priority instance for the tie-break variant.
module tb_ram_arbiter;
  import micro86_mem_pkg::*;

  localparam int AW   = 12;
  localparam int DW   = 8;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]    req = '0, we = '0, f_req = '0, f_we = '0;
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wdata [2];
  logic [AW-1:0] f_addr [2];
  logic [DW-1:0] f_wdata [2];

  logic          ack0, ack1, ram_write_enable;
  logic [DW-1:0] rdata0, rdata1, ram_data_in;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_dout = '0;

  logic          f_ack0, f_ack1, f_ram_we;
  logic [DW-1:0] f_rdata0, f_rdata1, f_ram_din;
  logic [AW-1:0] f_ram_addr;
  logic [DW-1:0] f_ram_dout = 8'h3C;

  ram_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req[0]), .we0(we[0]), .addr0(addr[0]), .wdata0(wdata[0]), .ack0(ack0),
    .rdata0(rdata0),
    .req1(req[1]), .we1(we[1]), .addr1(addr[1]), .wdata1(wdata[1]), .ack1(ack1),
    .rdata1(rdata1),
    .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_write_enable(ram_write_enable), .ram_data_out(ram_dout)
  );

  ram_arbiter #(.FIXED_PRIORITY(1)) dut_fp (
    .clk(clk), .reset_n(reset_n),
    .req0(f_req[0]), .we0(f_we[0]), .addr0(f_addr[0]), .wdata0(f_wdata[0]), .ack0(f_ack0),
    .rdata0(f_rdata0),
    .req1(f_req[1]), .we1(f_we[1]), .addr1(f_addr[1]), .wdata1(f_wdata[1]), .ack1(f_ack1),
    .rdata1(f_rdata1),
    .ram_address(f_ram_addr), .ram_data_in(f_ram_din),
    .ram_write_enable(f_ram_we), .ram_data_out(f_ram_dout)
  );

  int errors = 0;
  int checks = 0;

  function automatic void check(input string name, input logic [31:0] got,
                                input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endfunction

  function automatic logic [DW-1:0] pre(input int i);
    if (i == 0) return 8'h11;
    if (i == 4095) return 8'h22;
    return 8'(i) ^ 8'h5A;
  endfunction

  // Behavioural RAM: registered read, one-cycle latency.
  logic [DW-1:0] ram_mem [4096];
  initial begin
    for (int i = 0; i < 4096; i++) ram_mem[i] = pre(i);
    forever begin
      @(posedge clk);
      if (ram_write_enable) ram_mem[ram_address] <= ram_data_in;
      ram_dout <= ram_mem[ram_address];
    end
  end

  // Model: a grant taken at the end of idle cycle c schedules the RAM access in
  // c+1 and the ack in c+3; the arbiter is busy until c+4.
  int            cyc = 0;
  int            free_at = 0;
  int            m_last = 1;
  logic [DW-1:0] m_rd0 = '0, m_rd1 = '0;
  logic [DW-1:0] model_mem [4096];
  bit            exp_issue [MAXC], exp_we [MAXC], exp_ack0 [MAXC], exp_ack1 [MAXC];
  bit            exp_rdv [MAXC];
  int            exp_rdport [MAXC];
  logic [AW-1:0] exp_addr [MAXC];
  logic [DW-1:0] exp_din [MAXC], exp_rdval [MAXC];

  initial begin
    int c, p;
    logic [AW-1:0] a;
    for (int i = 0; i < 4096; i++) model_mem[i] = pre(i);
    forever begin
      @(posedge clk or negedge reset_n);
      if (clk) begin
        c = cyc;
        if (reset_n && c >= free_at && (req[0] || req[1]) && c + 3 < MAXC) begin
          if (req[0] && req[1]) p = (m_last == 0) ? 1 : 0;
          else p = req[1] ? 1 : 0;
          a = addr[p];
          exp_issue[c+1] = 1'b1;
          exp_addr[c+1]  = a;
          exp_we[c+1]    = we[p];
          exp_din[c+1]   = wdata[p];
          if (p == 0) exp_ack0[c+3] = 1'b1;
          else exp_ack1[c+3] = 1'b1;
          if (we[p]) begin
            model_mem[a] = wdata[p];
          end else begin
            exp_rdv[c+3]    = 1'b1;
            exp_rdport[c+3] = p;
            exp_rdval[c+3]  = model_mem[a];
          end
          m_last  = p;
          free_at = c + 4;
        end
        if (!reset_n) free_at = c + 1;
        cyc = c + 1;
        if (cyc < MAXC && exp_rdv[cyc]) begin
          if (exp_rdport[cyc] == 0) m_rd0 = exp_rdval[cyc];
          else m_rd1 = exp_rdval[cyc];
        end
      end else begin
        // Async reset abandons anything in flight.
        for (int i = cyc; i < MAXC; i++) begin
          exp_issue[i] = 1'b0; exp_we[i] = 1'b0; exp_ack0[i] = 1'b0;
          exp_ack1[i]  = 1'b0; exp_rdv[i] = 1'b0;
        end
        m_rd0  = '0;
        m_rd1  = '0;
        m_last = 1;
      end
    end
  end

  // Per-cycle compare against the model, plus event logging for directed checks.
  int            log_port [$];
  int            log_cyc [$];
  int            f_log [$];
  int            ack0_cnt = 0, ack1_cnt = 0, we_pulses = 0;
  logic [AW-1:0] last_we_addr = '0;
  logic [DW-1:0] last_we_din = '0;

  initial forever begin
    @(negedge clk);
    if (ack0) begin log_port.push_back(0); log_cyc.push_back(cyc); ack0_cnt++; end
    if (ack1) begin log_port.push_back(1); log_cyc.push_back(cyc); ack1_cnt++; end
    if (ram_write_enable) begin
      we_pulses++;
      last_we_addr = ram_address;
      last_we_din  = ram_data_in;
    end
    if (f_ack0) f_log.push_back(0);
    if (f_ack1) f_log.push_back(1);
    if (cyc < MAXC) begin
      check("ack0", 32'(ack0), 32'(exp_ack0[cyc]));
      check("ack1", 32'(ack1), 32'(exp_ack1[cyc]));
      check("ram_write_enable", 32'(ram_write_enable), 32'(exp_we[cyc]));
      if (exp_issue[cyc]) check("ram_address", 32'(ram_address), 32'(exp_addr[cyc]));
      if (exp_issue[cyc] && exp_we[cyc])
        check("ram_data_in", 32'(ram_data_in), 32'(exp_din[cyc]));
      check("rdata0", 32'(rdata0), 32'(m_rd0));
      check("rdata1", 32'(rdata1), 32'(m_rd1));
    end
  end

  task automatic set_req(input int inst, input int p, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (inst == 0) begin
      req[p] = r; we[p] = w; addr[p] = a; wdata[p] = d;
    end else begin
      f_req[p] = r; f_we[p] = w; f_addr[p] = a; f_wdata[p] = d;
    end
  endtask

  function automatic logic get_ack(input int inst, input int p);
    if (inst == 0) return (p == 0) ? ack0 : ack1;
    return (p == 0) ? f_ack0 : f_ack1;
  endfunction

  function automatic logic [DW-1:0] get_rdata(input int inst, input int p);
    if (inst == 0) return (p == 0) ? rdata0 : rdata1;
    return (p == 0) ? f_rdata0 : f_rdata1;
  endfunction

  // One requester transaction; hold keeps req high through the ack cycle.
  task automatic do_req(input int inst, input int p, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit hold,
                        output int t_req, output int t_ack, output logic [DW-1:0] rd);
    bit done;
    done  = 1'b0;
    t_ack = -1;
    rd    = '0;
    @(negedge clk);
    set_req(inst, p, 1'b1, w, a, d);
    t_req = cyc;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (get_ack(inst, p)) begin
        done  = 1'b1;
        t_ack = cyc;
        rd    = get_rdata(inst, p);
      end
    end
    check($sformatf("ack_seen_inst%0d_port%0d", inst, p), 32'(done), 32'd1);
    if (hold) @(negedge clk);
    set_req(inst, p, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "time limit");
  end

  initial begin
    int tr, ta, tr1, ta1, base, n1, wp;
    logic [DW-1:0] rd, rd1;
    for (int i = 0; i < 2; i++) begin
      addr[i] = '0; wdata[i] = '0; f_addr[i] = '0; f_wdata[i] = '0;
    end
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_ack0", 32'(ack0), 32'd0);
    check("reset_ram_we", 32'(ram_write_enable), 32'd0);
    check("reset_ram_address", 32'(ram_address), 32'd0);
    check("reset_rdata1", 32'(rdata1), 32'd0);
    #1 reset_n = 1'b1;

    // Port 0 write then read back.
    wp = we_pulses; n1 = ack1_cnt;
    do_req(0, 0, 1'b1, 12'h123, 8'hA5, 1'b0, tr, ta, rd);
    #1;
    check("wr_latency", 32'(ta - tr), 32'd3);
    check("wr_we_pulses", 32'(we_pulses - wp), 32'd1);
    check("wr_we_addr", 32'(last_we_addr), 32'h123);
    check("wr_we_data", 32'(last_we_din), 32'hA5);
    check("wr_no_ack1", 32'(ack1_cnt), 32'(n1));
    wp = we_pulses;
    do_req(0, 0, 1'b0, 12'h123, 8'h00, 1'b0, tr, ta, rd);
    #1;
    check("rd_latency", 32'(ta - tr), 32'd3);
    check("rd_data", 32'(rd), 32'hA5);
    check("rd_no_we", 32'(we_pulses - wp), 32'd0);

    // Port 1 write holding req through the ack cycle: exactly one access.
    wp = we_pulses; n1 = ack1_cnt;
    do_req(0, 1, 1'b1, 12'h200, 8'h77, 1'b1, tr, ta, rd);
    repeat (6) @(negedge clk);
    #1;
    check("hold_we_pulses", 32'(we_pulses - wp), 32'd1);
    check("hold_ack1_count", 32'(ack1_cnt - n1), 32'd1);

    // Simultaneous reads: port 0 wins the tie after a port 1 grant.
    base = log_port.size();
    fork
      do_req(0, 0, 1'b0, 12'h000, 8'h00, 1'b0, tr, ta, rd);
      do_req(0, 1, 1'b0, 12'hFFF, 8'h00, 1'b0, tr1, ta1, rd1);
    join
    #1;
    check("tie_rdata0", 32'(rd), 32'h11);
    check("tie_rdata1", 32'(rd1), 32'h22);
    check("tie_first_latency", 32'(ta - tr), 32'd3);
    check("tie_second_after", 32'(ta1 - ta), 32'd4);
    check("tie_order_first", 32'(log_port[base]), 32'd0);

    // Continuous requests from both ports alternate, one ack per four cycles.
    base = log_port.size();
    fork
      begin
        do_req(0, 0, 1'b1, 12'h010, 8'h01, 1'b0, tr, ta, rd);
        do_req(0, 0, 1'b0, 12'h010, 8'h00, 1'b0, tr, ta, rd);
        check("rr_p0_read", 32'(rd), 32'h01);
        do_req(0, 0, 1'b1, 12'h7FF, 8'hC3, 1'b0, tr, ta, rd);
        do_req(0, 0, 1'b0, 12'h7FF, 8'h00, 1'b0, tr, ta, rd);
        check("rr_p0_read2", 32'(rd), 32'hC3);
      end
      begin
        do_req(0, 1, 1'b0, 12'h123, 8'h00, 1'b0, tr1, ta1, rd1);
        check("rr_p1_read", 32'(rd1), 32'hA5);
        do_req(0, 1, 1'b1, 12'h020, 8'h99, 1'b0, tr1, ta1, rd1);
        do_req(0, 1, 1'b0, 12'h020, 8'h00, 1'b0, tr1, ta1, rd1);
        check("rr_p1_read2", 32'(rd1), 32'h99);
        do_req(0, 1, 1'b0, 12'h200, 8'h00, 1'b0, tr1, ta1, rd1);
        check("rr_p1_read3", 32'(rd1), 32'h77);
      end
    join
    #1;
    check("rr_count", 32'(log_port.size() - base), 32'd8);
    for (int i = 0; i < 8 && base + i < log_port.size(); i++) begin
      check($sformatf("rr_port_%0d", i), 32'(log_port[base+i]), 32'(i % 2));
      if (i > 0) check($sformatf("rr_gap_%0d", i),
                       32'(log_cyc[base+i] - log_cyc[base+i-1]), 32'd4);
    end

    // Fixed priority: port 0 re-requesting immediately beats a waiting port 1.
    fork
      begin
        do_req(1, 0, 1'b0, 12'h0A1, 8'h00, 1'b0, tr, ta, rd);
        do_req(1, 0, 1'b0, 12'h0A1, 8'h00, 1'b0, tr, ta, rd);
        check("fp_rdata0", 32'(rd), 32'h3C);
      end
      begin
        do_req(1, 1, 1'b0, 12'h0B2, 8'h00, 1'b0, tr1, ta1, rd1);
        check("fp_rdata1", 32'(rd1), 32'h3C);
      end
    join
    #1;
    check("fp_count", 32'(f_log.size()), 32'd3);
    if (f_log.size() == 3) begin
      check("fp_order0", 32'(f_log[0]), 32'd0);
      check("fp_order1", 32'(f_log[1]), 32'd0);
      check("fp_order2", 32'(f_log[2]), 32'd1);
    end
    check("fp_ram_we_idle", 32'(f_ram_we), 32'd0);
    check("fp_ram_address", 32'(f_ram_addr), 32'h0B2);
    check("fp_ram_data_in", 32'(f_ram_din), 32'h00);

    // Reset during CAPTURE of a port 1 read.
    @(negedge clk);
    set_req(0, 1, 1'b1, 1'b0, 12'hFFF, 8'h00);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_reset_ack1", 32'(ack1), 32'd0);
    check("mid_reset_ram_we", 32'(ram_write_enable), 32'd0);
    check("mid_reset_ram_address", 32'(ram_address), 32'd0);
    check("mid_reset_ram_data_in", 32'(ram_data_in), 32'd0);
    check("mid_reset_rdata0", 32'(rdata0), 32'd0);
    check("mid_reset_rdata1", 32'(rdata1), 32'd0);
    set_req(0, 1, 1'b0, 1'b0, '0, '0);
    n1 = ack1_cnt;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    check("no_ack1_after_reset", 32'(ack1_cnt), 32'(n1));
    do_req(0, 1, 1'b0, 12'hFFF, 8'h00, 1'b0, tr, ta, rd);
    #1;
    check("post_reset_latency", 32'(ta - tr), 32'd3);
    check("post_reset_rdata1", 32'(rd), 32'h22);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
